// File: rtl/addsub_seq_defs.sv
// Shared definitions for the nibble-serial add/sub sequencer:
// FSM state encoding and slice width.
package addsub_seq_defs;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_sub_4bit.sv
// One 4-bit add/sub slice. b is inverted when sub=1; the carry-in is taken
// as given, so the caller must inject 1 on the first nibble of a subtract.
module adder_sub_4bit
  import addsub_seq_defs::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic [NIB_W-1:0] sum,
  output logic             c_out
);
  logic [NIB_W-1:0] b_eff;

  assign b_eff = b ^ {NIB_W{sub}};
  assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{NIB_W{1'b0}}, c_in};
endmodule

// File: rtl/addsub_nibble_seq.sv
// Wide add/subtract computed one nibble per cycle, LSB first, through a
// single 4-bit slice. Carry, subtract carry-in and signed overflow live here.
module addsub_nibble_seq
  import addsub_seq_defs::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_sub,
  input  logic                 op_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_ovf,
  output logic                 busy,
  output logic [1:0]           fsm_state
);
  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;
  logic             carry;
  logic [IDX_W-1:0] nib_idx;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last;

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. Ready/valid here come from registered state only; the
  // requester keeps start_valid and operands steady until accepted, and
  // results stay frozen in DONE until res_ready is seen.
  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign busy        = (state == ST_RUN) || (state == ST_DONE);
  assign fsm_state   = state;
  assign accept      = start_valid && start_ready;
  assign last        = (nib_idx == LAST_IDX);

  assign a_nib = a_q[nib_idx*NIB_W +: NIB_W];
  assign b_nib = b_q[nib_idx*NIB_W +: NIB_W];

  adder_sub_4bit u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .sub   (sub_q),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE: if (res_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry    <= 1'b0;
      nib_idx  <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b;
      sub_q   <= op_sub;
      // Subtract is A + ~B + 1: the +1 enters as the first nibble's carry.
      carry   <= op_sub | op_cin;
      nib_idx <= '0;
    end else if (state == ST_RUN) begin
      res_sum[nib_idx*NIB_W +: NIB_W] <= slice_sum;
      carry <= slice_cout;
      if (last) begin
        res_cout <= slice_cout;
        res_ovf  <= (a_nib[NIB_W-1] ~^ (b_nib[NIB_W-1] ^ sub_q)) &
                    (slice_sum[NIB_W-1] ^ a_nib[NIB_W-1]);
      end else begin
        nib_idx <= nib_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Bench for addsub_nibble_seq: NIBBLES=4 directed/random tests plus
// NIBBLES=2 and 8 instances checked against an arithmetic reference model.
module tb_addsub_nibble_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op_a, op_b;
  logic        op_sub, op_cin;

  logic        sv4, sr4, rv4, rr4, cout4, ovf4, busy4;
  logic [15:0] sum4;
  logic [1:0]  st4;
  logic        sv2, sr2, rv2, rr2, cout2, ovf2, busy2;
  logic [7:0]  sum2;
  logic [1:0]  st2;
  logic        sv8, sr8, rv8, rr8, cout8, ovf8, busy8;
  logic [31:0] sum8;
  logic [1:0]  st8;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  addsub_nibble_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .op_sub(op_sub), .op_cin(op_cin),
    .res_valid(rv4), .res_ready(rr4), .res_sum(sum4), .res_cout(cout4),
    .res_ovf(ovf4), .busy(busy4), .fsm_state(st4)
  );

  addsub_nibble_seq #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]), .op_sub(op_sub), .op_cin(op_cin),
    .res_valid(rv2), .res_ready(rr2), .res_sum(sum2), .res_cout(cout2),
    .res_ovf(ovf2), .busy(busy2), .fsm_state(st2)
  );

  addsub_nibble_seq #(.NIBBLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
    .res_valid(rv8), .res_ready(rr8), .res_sum(sum8), .res_cout(cout8),
    .res_ovf(ovf8), .busy(busy8), .fsm_state(st8)
  );

  // Reference: unsigned result/carry and signed range check on plain integers.
  function automatic logic [33:0] model(input int n, input logic [31:0] a, b,
                                        input logic sub, cin);
    longint unsigned modv, ua, ub, ur;
    longint sa, sb, sr, half;
    logic cout, ovf;
    modv = 64'd1 << (4 * n);
    half = longint'(modv / 2);
    ua = {32'd0, a} & (modv - 1);
    ub = {32'd0, b} & (modv - 1);
    sa = (longint'(ua) >= half) ? longint'(ua) - longint'(modv) : longint'(ua);
    sb = (longint'(ub) >= half) ? longint'(ub) - longint'(modv) : longint'(ub);
    if (sub) begin
      ur   = ua - ub;
      cout = (ua >= ub);
      sr   = sa - sb;
    end else begin
      ur   = ua + ub + {63'd0, cin};
      cout = (ur >= modv);
      sr   = sa + sb + longint'(cin);
    end
    ovf = (sr > half - 1) || (sr < -half);
    ur  = ur & (modv - 1);
    return {ovf, cout, ur[31:0]};
  endfunction

  function automatic int nib_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic get_sr(input int idx);
    case (idx)
      0:       return sr4;
      1:       return sr2;
      default: return sr8;
    endcase
  endfunction

  function automatic logic get_rv(input int idx);
    case (idx)
      0:       return rv4;
      1:       return rv2;
      default: return rv8;
    endcase
  endfunction

  function automatic logic [33:0] get_res(input int idx);
    case (idx)
      0:       return {ovf4, cout4, 16'd0, sum4};
      1:       return {ovf2, cout2, 24'd0, sum2};
      default: return {ovf8, cout8, sum8};
    endcase
  endfunction

  task automatic set_sv(input int idx, input logic v);
    case (idx)
      0:       sv4 = v;
      1:       sv2 = v;
      default: sv8 = v;
    endcase
  endtask

  task automatic set_rr(input int idx, input logic v);
    case (idx)
      0:       rr4 = v;
      1:       rr2 = v;
      default: rr8 = v;
    endcase
  endtask

  // Driver: one full operation; lat = edges from accept to res_valid, -1 on timeout.
  task automatic run_op(input int idx, input logic [31:0] a, b, input logic sub, cin,
                        output logic [33:0] res, output int lat);
    int k;
    op_a = a; op_b = b; op_sub = sub; op_cin = cin;
    set_rr(idx, 1'b0);
    set_sv(idx, 1'b1);
    lat = -1;
    k = 0;
    while (!get_sr(idx) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    set_sv(idx, 1'b0);
    op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom); op_cin = 1'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (get_rv(idx)) begin
        lat = c;
        break;
      end
    end
    res = get_res(idx);
    set_rr(idx, 1'b1);
    @(posedge clk); #1;
    set_rr(idx, 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (sr4 !== 1'b1)   begin errors++; $display("FAIL reset_start_ready: got %b want 1", sr4); end
    checks++; if (rv4 !== 1'b0)   begin errors++; $display("FAIL reset_res_valid: got %b want 0", rv4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy4); end
    checks++; if (sum4 !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum4); end
    checks++; if ({cout4, ovf4} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b want 00", {cout4, ovf4}); end
    checks++; if (st4 !== 2'd0)   begin errors++; $display("FAIL reset_state: got %0d want 0", st4); end
    checks++; if ({sr2, rv2, sr8, rv8} !== 4'b1010) begin errors++; $display("FAIL reset_sweep_handshake: got %b want 1010", {sr2, rv2, sr8, rv8}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [33:0] res;
    int lat;
    run_op(0, 32'h1234, 32'h0FFF, 1'b0, 1'b0, res, lat);
    checks++; if (res[15:0] !== 16'h2233) begin errors++; $display("FAIL add_sum: got %h want 2233", res[15:0]); end
    checks++; if (res[33:32] !== 2'b00)   begin errors++; $display("FAIL add_ovf_cout: got %b want 00", res[33:32]); end
    checks++; if (lat !== 4)              begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
  endtask

  task automatic test_sub();
    logic [15:0] ta[2] = '{16'h0005, 16'h0007};
    logic [15:0] tb[2] = '{16'h0007, 16'h0005};
    logic [15:0] ts[2] = '{16'hFFFE, 16'h0002};
    logic        tc[2] = '{1'b0, 1'b1};
    logic [33:0] res;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(0, {16'd0, ta[i]}, {16'd0, tb[i]}, 1'b1, 1'b0, res, lat);
      checks++; if (res[15:0] !== ts[i]) begin errors++; $display("FAIL sub_sum[%0d]: got %h want %h", i, res[15:0], ts[i]); end
      checks++; if (res[32] !== tc[i])   begin errors++; $display("FAIL sub_cout[%0d]: got %b want %b", i, res[32], tc[i]); end
      checks++; if (res[33] !== 1'b0)    begin errors++; $display("FAIL sub_ovf[%0d]: got %b want 0", i, res[33]); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ta[3] = '{16'h7FFF, 16'hFFFF, 16'h8000};
    logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        tsub[3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] ts[3] = '{16'h8000, 16'h0000, 16'h7FFF};
    logic        tc[3] = '{1'b0, 1'b1, 1'b1};
    logic        tv[3] = '{1'b1, 1'b0, 1'b1};
    logic [33:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(0, {16'd0, ta[i]}, {16'd0, tb[i]}, tsub[i], 1'b0, res, lat);
      checks++; if (res[15:0] !== ts[i]) begin errors++; $display("FAIL ovf_sum[%0d]: got %h want %h", i, res[15:0], ts[i]); end
      checks++; if (res[32] !== tc[i])   begin errors++; $display("FAIL ovf_cout[%0d]: got %b want %b", i, res[32], tc[i]); end
      checks++; if (res[33] !== tv[i])   begin errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, res[33], tv[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    op_a = 32'h00A5; op_b = 32'h0003; op_sub = 1'b0; op_cin = 1'b0;
    rr4 = 1'b0; sv4 = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h0100; op_b = 32'h0001;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rv4) begin lat = c; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int c = 0; c < 3; c++) begin
      checks++; if ({rv4, sr4, busy4} !== 3'b101) begin errors++; $display("FAIL bp_handshake[%0d]: got %b want 101", c, {rv4, sr4, busy4}); end
      checks++; if ({ovf4, cout4, sum4} !== {2'b00, 16'h00A8}) begin errors++; $display("FAIL bp_hold[%0d]: got %h want 00a8", c, sum4); end
      @(posedge clk); #1;
    end
    rr4 = 1'b1;
    @(posedge clk); #1;
    rr4 = 1'b0;
    checks++; if ({rv4, sr4} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b want 01", {rv4, sr4}); end
    @(posedge clk); #1;
    sv4 = 1'b0;
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL bp_pending_accept: got %b want 1", busy4); end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rv4) begin lat = c; break; end
    end
    checks++; if (lat !== 4 || sum4 !== 16'h0101) begin errors++; $display("FAIL bp_second_op: got lat %0d sum %h want 4 0101", lat, sum4); end
    rr4 = 1'b1;
    @(posedge clk); #1;
    rr4 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [33:0] res;
    int lat;
    op_a = 32'h1111; op_b = 32'h2222; op_sub = 1'b0; op_cin = 1'b0;
    sv4 = 1'b1;
    @(posedge clk); #1;
    sv4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({sr4, rv4, busy4, st4} !== 5'b10000) begin errors++; $display("FAIL midrun_ctrl: got %b want 10000", {sr4, rv4, busy4, st4}); end
    checks++; if ({ovf4, cout4, sum4} !== 18'h0) begin errors++; $display("FAIL midrun_outputs: got %h want 0", {ovf4, cout4, sum4}); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 32'h00FF, 32'h0001, 1'b0, 1'b1, res, lat);
    checks++; if (res[15:0] !== 16'h0101 || res[33:32] !== 2'b00) begin errors++; $display("FAIL midrun_next_op: got %h want 00101", res[17:0]); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrun_latency: got %0d want 4", lat); end
  endtask

  // res_ready and start_valid held high: expect one accept every NIBBLES+2 cycles.
  task automatic test_back_to_back();
    int accepts = 0;
    int last_acc = -1;
    int cyc = 0;
    logic [33:0] m;
    logic [17:0] e;
    rr4 = 1'b1;
    sv4 = 1'b1;
    while ((accepts < 6 || exp_q.size() > 0) && cyc < 200) begin
      if (rv4) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got %h with empty queue", sum4); end
        else begin
          e = exp_q.pop_front();
          if ({ovf4, cout4, sum4} !== e) begin errors++; $display("FAIL b2b_result: got %h want %h", {ovf4, cout4, sum4}, e); end
        end
      end
      if (sr4 && sv4) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 6) begin errors++; $display("FAIL b2b_spacing: got %0d want 6", cyc - last_acc); end
        end
        last_acc = cyc;
        op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom); op_cin = 1'($urandom);
        m = model(4, op_a, op_b, op_sub, op_cin);
        exp_q.push_back({m[33:32], m[15:0]});
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepts >= 6) sv4 = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    rr4 = 1'b0;
    sv4 = 1'b0;
  endtask

  task automatic test_sweep();
    int idxs[3] = '{0, 1, 2};
    logic [31:0] a, b;
    logic sub, cin;
    logic [33:0] res, m;
    int lat;
    foreach (idxs[j]) begin
      for (int i = 0; i < 12; i++) begin
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        if (i == 0) begin a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; sub = 1'b0; end
        m = model(nib_of(idxs[j]), a, b, sub, cin);
        run_op(idxs[j], a, b, sub, cin, res, lat);
        checks++; if (res !== m) begin errors++; $display("FAIL sweep_n%0d_result[%0d]: got %h want %h", nib_of(idxs[j]), i, res, m); end
        checks++; if (lat != nib_of(idxs[j])) begin errors++; $display("FAIL sweep_n%0d_latency[%0d]: got %0d want %0d", nib_of(idxs[j]), i, lat, nib_of(idxs[j])); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0; op_cin = 1'b0;
    sv4 = 1'b0; rr4 = 1'b0;
    sv2 = 1'b0; rr2 = 1'b0;
    sv8 = 1'b0; rr8 = 1'b0;
    #12;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_nibble_seq.md
# addsub_nibble_seq

Multi-cycle sequencer that performs a wide (4×NIBBLES-bit) add or subtract by time-multiplexing a single 4-bit add/sub slice over successive nibbles, LSB first. The block sits between an operand producer and a result consumer, each with a valid/ready handshake. It owns carry propagation between nibbles, subtract carry-in injection, and signed-overflow detection, so the datapath stays one 4-bit slice wide.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4*NIBBLES; default 16 bits); legal range 2..16.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  operand request valid.
- start_ready  out  1  block can accept a request (high only in IDLE).
- op_a  in  W  minuend / addend A.
- op_b  in  W  subtrahend / addend B.
- op_sub  in  1  1 = A − B, 0 = A + B.
- op_cin  in  1  carry-in for add; ignored when op_sub=1.
- res_valid  out  1  result valid (high only in DONE).
- res_ready  in  1  consumer accepts result.
- res_sum  out  W  result.
- res_cout  out  1  final carry-out; for subtract, 1 = no borrow (A ≥ B unsigned).
- res_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. When start_valid & start_ready, latch op_a, op_b, op_sub. Set carry register to 1 if op_sub, else op_cin. Clear nib_idx to 0. Go to RUN.
- RUN: the slice sees a = A[4*idx+:4], b = B[4*idx+:4], sub = latched sub, c_in = carry register. Each cycle:
  - write the slice sum into res_sum[4*idx+:4];
  - carry register ← slice c_out;
  - nib_idx ← nib_idx+1.
  - When nib_idx == NIBBLES−1, also go to DONE and capture res_cout = slice c_out.
  - Also capture res_ovf = (A_msb ~^ (B_msb ^ sub)) & (sum_msb ^ A_msb), using the top-nibble values.
- The slice inverts b when sub=1 but does not force its own carry-in; the controller's carry-in injection of 1 is mandatory for correct subtraction.
- DONE: res_valid=1. res_sum, res_cout and res_ovf are held stable until res_ready; then go to IDLE.
- start_valid during RUN/DONE is not accepted (start_ready=0); the requester holds its request.
- nib_idx width is clog2(NIBBLES); the index never wraps within an operation.

## Timing
- Reset (async assert, sync-safe deassert by the system): state=IDLE, start_ready=1, res_valid=0, busy=0, res_sum=0, res_cout=0, res_ovf=0, nib_idx=0, carry=0.
- Latency: accept edge E0 → res_valid high after edge E0+NIBBLES (RUN lasts exactly NIBBLES cycles).
- Throughput: with res_ready held high, one operation per NIBBLES+2 cycles (RUN×NIBBLES, DONE×1, IDLE×1).
- start_ready and res_valid are decoded from registered state only, with no combinational path from inputs.
- res_sum bits of nibbles not yet processed keep their previous values during RUN. Only the DONE-state value is defined.
- Reset asserted mid-RUN or mid-DONE aborts immediately with no result issued. The next accepted operation is fully correct.
- res_ready high outside DONE has no effect.

## Structure
- Shared header/package addsub_seq_defs holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIB_W=4.
- One sub-module instance: the existing 4-bit add/sub slice adder_sub_4bit, driven by nibble select muxes on latched A/B.
- Everything else (FSM, index counter, carry register, result register) is in addsub_nibble_seq.

## Test plan
- Add, NIBBLES=4: A=0x1234, B=0x0FFF, sub=0, cin=0 → sum=0x2233, cout=0, ovf=0. res_valid exactly 4 cycles after accept.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1, cin=0 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then A=0x0007, B=0x0005 → sum=0x0002, cout=1.
- Overflow and carry:
  - 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0.
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, ovf=1.
- Backpressure: hold res_ready=0 for 3 cycles in DONE → outputs stable, start_ready=0, and a pending start_valid is not accepted until after the result is taken.
- Reset mid-RUN: assert rst_n=0 on the 2nd RUN cycle → all outputs return to reset values asynchronously. Then 0x00FF+0x0001, cin=1 → sum=0x0101.
- Parameter sweep: NIBBLES=2 and 8 with random operands vs a reference model → sum/cout/ovf match and latency equals NIBBLES.
